// File: rtl/reg_file_wb.sv
// Purpose: 32-entry register file with a one-entry write-back buffer and two forwarding read ports.
// Latency: reads are combinational; a write is visible on the read ports the next cycle and reaches the array one cycle after that.
// Backpressure: none; one write per cycle is always accepted and the buffer never fills.
module reg_file_wb #(
    parameter int DATA_W   = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              pend_valid,
    output logic [4:0]        pend_addr
);

    typedef struct packed {
        logic              vld;
        logic [4:0]        addr;
        logic [DATA_W-1:0] dat;
    } pend_t;

    logic [DATA_W-1:0] regs [32];
    pend_t             pend_q;
    pend_t             pend_d;
    logic              wr_drop;

    // A write to register 0 is discarded when register 0 is hardwired to zero.
    assign wr_drop = ZERO_REG && (wr_addr == 5'd0);

    // Next buffer contents: a live write loads it, otherwise it empties to all-zero
    // so pend_addr reads 0 whenever nothing is pending.
    always_comb begin
        pend_d = '0;
        if (wr_en && !wr_drop) begin
            pend_d.vld  = 1'b1;
            pend_d.addr = wr_addr;
            pend_d.dat  = wr_data;
        end
    end

    // Pending buffer register; reset discards any uncommitted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Array commit from the buffer, on the same edge that may refill the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (pend_q.vld) begin
            regs[pend_q.addr] <= pend_q.dat;
        end
    end

    // Read ports: zero register first, then forward from the buffer, else the array.
    always_comb begin
        rs_data = regs[rs_addr];
        if (ZERO_REG && (rs_addr == 5'd0)) begin
            rs_data = '0;
        end else if (pend_q.vld && (rs_addr == pend_q.addr)) begin
            rs_data = pend_q.dat;
        end

        rt_data = regs[rt_addr];
        if (ZERO_REG && (rt_addr == 5'd0)) begin
            rt_data = '0;
        end else if (pend_q.vld && (rt_addr == pend_q.addr)) begin
            rt_data = pend_q.dat;
        end
    end

    assign pend_valid = pend_q.vld;
    assign pend_addr  = pend_q.addr;

endmodule
